led_puzzle_matrix: RTL
======================

LED_PUZZLE_MATRIX -- requirements
Module: led_puzzle_matrix

Interface
REQ-001 Parameter ROWS, default 8, matrix row count (>=2); LW = clog2(ROWS).
REQ-002 Parameter COLS, default 8, matrix column count (>=1).
REQ-003 Parameter NBTN, default 8, button count (>=1).
REQ-004 Parameter SCAN_DIV, default 1000, clk cycles per scanned row (>=1).
REQ-005 Parameter BTN_MASKS, NBTN*ROWS*COLS bits, toggle region per button; bit k*ROWS*COLS + r*COLS + c set = button k toggles cell (r,c); default: button k covers column k mod COLS, all rows.
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 botoes  input  NBTN  raw button levels, asynchronous, pre-debounced.
REQ-009 nivel  input  3  current level, quasi-static.
REQ-010 limpar  input  1  synchronous clear of board and move counter.
REQ-011 colunas  output  COLS  contents of scanned row, bit c = cell (linha,c).
REQ-012 linhas  output  LW  index of scanned row, binary.
REQ-013 nivel_concluido  output  1  registered win level flag.
REQ-014 vitoria  output  1  one-cycle win pulse.
REQ-015 jogadas  output  16  accepted-move counter.

Function
REQ-016 Board SHALL be a ROWS x COLS register array, each cell one bit.
REQ-017 Each botoes bit SHALL pass a 2-FF synchronizer; press event = synchronized rising edge (1 cycle), so a held button toggles exactly once.
REQ-018 In a cycle with press set P, board SHALL update to board XOR (OR-free XOR of BTN_MASKS[k] for all k in P); overlapping cells hit by an even count remain unchanged.
REQ-019 Latency: botoes bit high at setup of edge n -> board toggled after edge n+2 (visible from n+2).
REQ-020 A cycle with non-empty P, not locked and not clearing, SHALL increment jogadas by 1 (one per cycle regardless of |P|); saturate at 16'hFFFF.
REQ-021 Lock: while nivel_concluido=1, press events SHALL be ignored (no toggle, no count).
REQ-022 limpar=1 SHALL, on the next edge, zero board, jogadas, nivel_concluido, vitoria; limpar has priority over simultaneous presses; board stays zero while limpar held.
REQ-023 Target rows T: 2*nivel+1 if <= ROWS; ROWS if 2*nivel+1 == ROWS+1; otherwise invalid.
REQ-024 nivel_concluido SHALL register (rows 0..T-1 all ones) each cycle, 0 when T invalid or limpar=1; reflects board one cycle later; re-evaluated continuously on nivel change.
REQ-025 vitoria SHALL be 1 for exactly the cycle in which nivel_concluido goes 0->1.
REQ-026 Scan: prescaler counts 0..SCAN_DIV-1; on terminal count linhas SHALL advance, wrapping ROWS-1 -> 0; SCAN_DIV=1 advances every cycle.
REQ-027 colunas SHALL be combinational from current board row linhas (same-cycle board updates visible immediately).
REQ-028 Scan SHALL run independently of presses, lock and limpar.

Reset
REQ-029 rst=1 SHALL immediately clear board, synchronizers, edge detectors, prescaler, linhas, jogadas, nivel_concluido, vitoria to 0; colunas therefore 0.
REQ-030 After rst deasserts, a button already held high SHALL produce one press event (sync FFs start at 0).
REQ-031 rst asserted mid-press or mid-scan SHALL discard the pending event; no partial toggle.

Verification (defaults, SCAN_DIV=4 unless noted)
REQ-032 Reset, hold botoes[0] high 100 cycles -> every row bit0=1, others 0; jogadas=1; toggle visible 2 edges after first sample.
REQ-033 nivel=0, botoes=8'hFF for 5 cycles -> board all ones; nivel_concluido=1 one cycle later; vitoria single pulse; jogadas=1.
REQ-034 After REQ-033, press botoes[3] -> board unchanged, jogadas=1; pulse limpar -> board 0, nivel_concluido=0, jogadas=0 next cycle.
REQ-035 Full board, nivel=5 -> nivel_concluido=0; nivel=4 -> 1 next cycle with vitoria pulse; nivel=1 with rows 0..2 full, row 3 empty -> 1.
REQ-036 Scan: linhas 0,1..7,0 stepping every 4 clk; colunas equals addressed row; botoes[0]+botoes[8 mod COLS] simultaneously with custom mask overlap -> shared cells unchanged.
REQ-037 Assert rst mid-scan with button edge in synchronizer -> all outputs 0 same cycle; no toggle after release.

Source files
------------

// File: rtl/led_puzzle_matrix.sv
// Button-driven LED toggle puzzle. The board is a ROWS x COLS bit matrix that is
// XOR-toggled by debounced button edges and scanned out one row at a time.
package led_puzzle_matrix_pkg;
  localparam int MAX_MASK_BITS = 4096;

  // Default toggle regions: button k owns column (k mod cols) across every row.
  function automatic logic [MAX_MASK_BITS-1:0] default_btn_masks(input int rows, input int cols,
                                                                 input int nbtn);
    logic [MAX_MASK_BITS-1:0] m;
    m = '0;
    for (int k = 0; k < nbtn; k++) begin
      for (int r = 0; r < rows; r++) begin
        if (k * rows * cols + r * cols + (k % cols) < MAX_MASK_BITS)
          m[k * rows * cols + r * cols + (k % cols)] = 1'b1;
      end
    end
    return m;
  endfunction
endpackage

module led_puzzle_matrix #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int NBTN     = 8,
  parameter int SCAN_DIV = 1000,
  parameter logic [NBTN*ROWS*COLS-1:0] BTN_MASKS =
    (NBTN*ROWS*COLS)'(led_puzzle_matrix_pkg::default_btn_masks(ROWS, COLS, NBTN)),
  localparam int LW = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] botoes,
  input  logic [2:0]      nivel,
  input  logic            limpar,
  output logic [COLS-1:0] colunas,
  output logic [LW-1:0]   linhas,
  output logic            nivel_concluido,
  output logic            vitoria,
  output logic [15:0]     jogadas
);
  localparam int CELLS = ROWS * COLS;
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NBTN-1:0]            sync_1, sync_2, btn_prev, press;
  logic [ROWS-1:0][COLS-1:0]  board, toggle;
  logic [PW-1:0]              presc;
  int                         target_rows;
  logic                       win_next;

  // NOTE: every register below uses non-blocking assignment so all state updates
  // see the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1   <= '0;
      sync_2   <= '0;
      btn_prev <= '0;
    end else begin
      sync_1   <= botoes;
      sync_2   <= sync_1;
      btn_prev <= sync_2;
    end
  end

  assign press = sync_2 & ~btn_prev;

  // Overlapping regions cancel pairwise, so the combined toggle is a pure XOR.
  always_comb begin
    toggle = '0;
    for (int k = 0; k < NBTN; k++) begin
      if (press[k]) toggle = toggle ^ BTN_MASKS[k*CELLS +: CELLS];
    end
  end

  // Level n asks for the first 2n+1 rows lit; one past the board clamps to full board.
  always_comb begin
    target_rows = 2 * int'(nivel) + 1;
    if (target_rows == ROWS + 1) target_rows = ROWS;
    win_next = (target_rows <= ROWS);
    for (int r = 0; r < ROWS; r++) begin
      if (r < target_rows && board[r] != '1) win_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board           <= '0;
      jogadas         <= '0;
      nivel_concluido <= 1'b0;
      vitoria         <= 1'b0;
    end else if (limpar) begin
      board           <= '0;
      jogadas         <= '0;
      nivel_concluido <= 1'b0;
      vitoria         <= 1'b0;
    end else begin
      if (!nivel_concluido) begin
        board <= board ^ toggle;
        if (|press && jogadas != 16'hFFFF) jogadas <= jogadas + 16'd1;
      end
      nivel_concluido <= win_next;
      vitoria         <= win_next & ~nivel_concluido;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      linhas <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc  <= '0;
      linhas <= (linhas == LW'(ROWS - 1)) ? '0 : linhas + LW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign colunas = board[linhas];

endmodule
